// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mem_responder_if : CPU request bus plus cartridge ROM side-channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface cpu_mem_responder_if;
  logic        memory_access;
  logic        rw_n;
  logic [15:0] addr_bus;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_ready;
  logic        busy;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ack;
  logic        bus_err;

  // slave: the responder itself; master: the CPU/ROM environment
  modport slave (
    input  memory_access, rw_n, addr_bus, mem_data_out, rom_data, rom_ack,
    output mem_data_in, mem_ready, busy, rom_req, rom_addr, bus_err
  );

  modport master (
    output memory_access, rw_n, addr_bus, mem_data_out, rom_data, rom_ack,
    input  mem_data_in, mem_ready, busy, rom_req, rom_addr, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mem_responder : work-RAM / cartridge-ROM responder for a CPU bus
// Rev 1.0
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int RAM_AW      = 11,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  cpu_mem_responder_if.slave bus
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RAM      = 2'd1;
  localparam logic [1:0] c_ROM_WAIT = 2'd2;
  localparam logic [1:0] c_MISC     = 2'd3;

  localparam int                 c_CNT_W     = $clog2(ROM_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(ROM_TIMEOUT - 1);
  localparam int                 c_RAM_DEPTH = 1 << RAM_AW;

  logic [1:0]         state_q, state_d;
  logic               prev_acc_q;
  logic [14:0]        addr_q;
  logic               rw_n_q;
  logic [7:0]         wdata_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [7:0]         rdata_q;
  logic               mem_ready_q, mem_ready_d;
  logic               bus_err_q, bus_err_d;
  logic               rom_req_q, rom_req_d;
  logic [7:0]         ram_q [c_RAM_DEPTH];

  logic w_accept, w_is_ram, w_is_rom_rd, w_timeout;
  logic w_load_ram, w_load_rom, w_ram_we;

  assign w_accept    = (state_q == c_IDLE) && bus.memory_access && !prev_acc_q;
  assign w_is_ram    = (bus.addr_bus[15:13] == 3'b000);
  assign w_is_rom_rd = bus.addr_bus[15] && bus.rw_n;
  // Counter holds the number of ROM_WAIT edges already spent, so the edge
  // that would make it reach ROM_TIMEOUT is the timeout edge.
  assign w_timeout   = (cnt_q == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          if (w_is_ram)         state_d = c_RAM;
          else if (w_is_rom_rd) state_d = c_ROM_WAIT;
          else                  state_d = c_MISC;
        end
      end
      c_RAM:      state_d = c_IDLE;
      c_ROM_WAIT: if (bus.rom_ack || w_timeout) state_d = c_IDLE;
      c_MISC:     state_d = c_IDLE;
      default:    state_d = c_IDLE;
    endcase
  end

  always_comb begin
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;
    rom_req_d   = 1'b0;
    w_load_ram  = 1'b0;
    w_load_rom  = 1'b0;
    w_ram_we    = 1'b0;
    case (state_q)
      c_IDLE: rom_req_d = w_accept && !w_is_ram && w_is_rom_rd;
      c_RAM: begin
        mem_ready_d = 1'b1;
        w_load_ram  = rw_n_q;
        w_ram_we    = !rw_n_q;
      end
      c_ROM_WAIT: begin
        if (bus.rom_ack) begin
          mem_ready_d = 1'b1;
          w_load_rom  = 1'b1;
        end else if (w_timeout) begin
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
        end else begin
          rom_req_d   = 1'b1;
        end
      end
      c_MISC:  mem_ready_d = 1'b1;
      default: mem_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_acc_q  <= 1'b0;
      addr_q      <= '0;
      rw_n_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rom_req_q   <= 1'b0;
    end else begin
      prev_acc_q  <= bus.memory_access;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      rom_req_q   <= rom_req_d;
      if (w_accept) begin
        addr_q  <= bus.addr_bus[14:0];
        rw_n_q  <= bus.rw_n;
        wdata_q <= bus.mem_data_out;
        cnt_q   <= '0;
      end else if (state_q == c_ROM_WAIT) begin
        cnt_q   <= cnt_q + 1'b1;
      end
      if (w_load_ram)      rdata_q <= ram_q[addr_q[RAM_AW-1:0]];
      else if (w_load_rom) rdata_q <= bus.rom_data;
    end
  end

  // Work RAM is never cleared; a reset landing on the write edge cancels it.
  always_ff @(posedge clk) begin
    if (w_ram_we && !rst) begin
      ram_q[addr_q[RAM_AW-1:0]] <= wdata_q;
    end
  end

  assign bus.mem_data_in = rdata_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.busy        = (state_q != c_IDLE);
  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = addr_q;
  assign bus.bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder : directed + randomized bench against a byte-array model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_responder_if bus();

  cpu_mem_responder #(.RAM_AW(11), .ROM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_ram [2048];
  logic [7:0] model_dout;
  logic [15:0] pool [8] = '{16'h0011, 16'h00A3, 16'h0155, 16'h0246,
                            16'h0388, 16'h04C9, 16'h060A, 16'h07FF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction; expectations come from the address map and the model.
  task automatic xact(input string tag, input logic rd, input logic [15:0] a,
                      input logic [7:0] wd, input int ack_dly,
                      input logic [7:0] ack_d, input bit extra);
    int exp_k, nrdy, rdy_k, nerr, err_k, ovl, rqbad;
    bit ram, rom_rd, exp_err;
    logic [7:0] exp_d;
    ram     = (a < 16'h2000);
    rom_rd  = (a >= 16'h8000) && rd;
    exp_err = rom_rd && !(ack_dly >= 1 && ack_dly <= TMO);
    exp_k   = rom_rd ? (exp_err ? TMO : ack_dly) : 1;
    exp_d   = model_dout;
    if (ram && rd)              exp_d = model_ram[a[10:0]];
    else if (rom_rd && !exp_err) exp_d = ack_d;

    bus.memory_access = 1'b1;
    bus.rw_n          = rd;
    bus.addr_bus      = a;
    bus.mem_data_out  = wd;
    bus.rom_ack       = 1'($urandom_range(0, 1));
    bus.rom_data      = 8'hEE;
    tick;
    bus.memory_access = 1'b0;
    bus.rom_ack       = 1'b0;
    bus.addr_bus      = 16'($urandom);
    bus.mem_data_out  = 8'($urandom);
    bus.rw_n          = 1'($urandom);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (rom_rd) chk({tag, "_romaddr"}, 32'(bus.rom_addr), 32'(a[14:0]));

    nrdy = 0; rdy_k = -1; nerr = 0; err_k = -1; ovl = 0; rqbad = 0;
    for (int j = 0; j < 20; j++) begin
      if (bus.mem_ready === 1'b1) begin
        nrdy++;
        if (rdy_k < 0) rdy_k = j;
      end
      if (bus.bus_err === 1'b1) begin
        nerr++;
        err_k = j;
      end
      if (bus.mem_ready === 1'b1 && bus.busy === 1'b1) ovl++;
      if (bus.rom_req !== (rom_rd && j < exp_k)) rqbad++;
      bus.rom_ack       = (j + 1 == ack_dly);
      bus.rom_data      = (j + 1 == ack_dly) ? ack_d : 8'hEE;
      bus.memory_access = extra && (j == 2);
      tick;
    end
    bus.rom_ack       = 1'b0;
    bus.memory_access = 1'b0;
    if (ram && !rd) model_ram[a[10:0]] = wd;
    model_dout = exp_d;

    chk({tag, "_nready"},  32'(nrdy),  32'd1);
    chk({tag, "_latency"}, 32'(rdy_k), 32'(exp_k));
    chk({tag, "_nbuserr"}, 32'(nerr),  32'(exp_err));
    if (exp_err) chk({tag, "_err_cycle"}, 32'(err_k), 32'(exp_k));
    chk({tag, "_rdy_busy"}, 32'(ovl),   32'd0);
    chk({tag, "_romreq"},   32'(rqbad), 32'd0);
    chk({tag, "_data"}, 32'(bus.mem_data_in), 32'(exp_d));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},    32'(bus.mem_data_in), 32'd0);
    chk({tag, "_ready"},   32'(bus.mem_ready),   32'd0);
    chk({tag, "_busy"},    32'(bus.busy),        32'd0);
    chk({tag, "_romreq"},  32'(bus.rom_req),     32'd0);
    chk({tag, "_romaddr"}, 32'(bus.rom_addr),    32'd0);
    chk({tag, "_buserr"},  32'(bus.bus_err),     32'd0);
  endtask

  initial begin
    int nrdy, nerr, cls, ack;
    logic [15:0] a;
    rst = 1'b1;
    bus.memory_access = 1'b0;
    bus.rw_n          = 1'b1;
    bus.addr_bus      = 16'h0;
    bus.mem_data_out  = 8'h0;
    bus.rom_data      = 8'h0;
    bus.rom_ack       = 1'b0;
    model_dout        = 8'h00;
    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;

    foreach (pool[i]) xact("init_wr", 1'b0, pool[i] + 16'($urandom_range(0, 3)) * 16'h0800,
                           8'($urandom), 0, 8'h00, 1'b0);

    xact("wr_0005",    1'b0, 16'h0005, 8'h5A, 0, 8'h00, 1'b0);
    xact("rd_1805",    1'b1, 16'h1805, 8'h00, 0, 8'h00, 1'b0);
    xact("rom_8123",   1'b1, 16'h8123, 8'h00, 3, 8'hC3, 1'b0);
    xact("rom_fffc",   1'b1, 16'hFFFC, 8'h00, 0, 8'h00, 1'b0);
    xact("wr_0777",    1'b0, 16'h0777, 8'h77, 0, 8'h00, 1'b0);
    xact("rd_0777",    1'b1, 16'h0777, 8'h00, 0, 8'h00, 1'b0);
    xact("rd_4016",    1'b1, 16'h4016, 8'h00, 0, 8'h00, 1'b0);
    xact("rom_drop",   1'b1, 16'hA000, 8'h00, 6, 8'h3C, 1'b1);
    xact("rom_ack15",  1'b1, 16'h8001, 8'h00, 15, 8'h96, 1'b0);
    xact("rom_ack1",   1'b1, 16'hC7FF, 8'h00, 1, 8'h21, 1'b0);
    xact("rom_late",   1'b1, 16'h8F00, 8'h00, 16, 8'h44, 1'b0);
    xact("rom_wr",     1'b0, 16'h9000, 8'h11, 2, 8'hAB, 1'b0);
    xact("unm_wr",     1'b0, 16'h3000, 8'h22, 0, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 3);
      ack = $urandom_range(0, 17);
      if (cls <= 1)      a = pool[$urandom_range(0, 7)] + 16'($urandom_range(0, 3)) * 16'h0800;
      else if (cls == 2) a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      else               a = 16'($urandom_range(16'h2000, 16'h7FFF));
      xact("rand", 1'($urandom), a, 8'($urandom), ack, 8'($urandom), 1'b0);
    end

    // Reset on the write edge of a RAM write must cancel the write.
    bus.memory_access = 1'b1;
    bus.rw_n          = 1'b0;
    bus.addr_bus      = pool[0];
    bus.mem_data_out  = ~model_ram[pool[0][10:0]];
    tick;
    bus.memory_access = 1'b0;
    rst = 1'b1;
    tick;
    chk_all_zero("rst_ramwr");
    rst = 1'b0;
    model_dout = 8'h00;
    tick;
    xact("rd_after_abort", 1'b1, pool[0], 8'h00, 0, 8'h00, 1'b0);

    // Reset in the middle of a ROM wait.
    bus.memory_access = 1'b1;
    bus.rw_n          = 1'b1;
    bus.addr_bus      = 16'h9234;
    tick;
    bus.memory_access = 1'b0;
    tick;
    tick;
    tick;
    chk("romwait_busy", 32'(bus.busy), 32'd1);
    chk("romwait_req",  32'(bus.rom_req), 32'd1);
    rst = 1'b1;
    tick;
    chk_all_zero("rst_romwait");
    rst = 1'b0;
    model_dout = 8'h00;
    nrdy = 0;
    nerr = 0;
    for (int j = 0; j < 20; j++) begin
      bus.rom_ack  = (j == 2);
      bus.rom_data = 8'hD7;
      tick;
      if (bus.mem_ready === 1'b1) nrdy++;
      if (bus.bus_err === 1'b1) nerr++;
    end
    bus.rom_ack = 1'b0;
    chk("post_rst_ready",  32'(nrdy), 32'd0);
    chk("post_rst_buserr", 32'(nerr), 32'd0);
    chk("post_rst_dout",   32'(bus.mem_data_in), 32'd0);
    xact("rd_1805_after_rst", 1'b1, 16'h1805, 8'h00, 0, 8'h00, 1'b0);

    // memory_access held high through reset release is a fresh request.
    rst = 1'b1;
    bus.memory_access = 1'b1;
    bus.rw_n          = 1'b1;
    bus.addr_bus      = 16'h0005;
    tick;
    tick;
    rst = 1'b0;
    model_dout = 8'h00;
    xact("acc_across_rst", 1'b1, 16'h0005, 8'h00, 0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, internal work-RAM address width (2 KB).
REQ-002 SHALL have parameter ROM_TIMEOUT, default 15, maximum cycles to wait for rom_ack.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memory_access  input  1  CPU request strobe.
REQ-006 SHALL have port rw_n  input  1  1 = read, 0 = write.
REQ-007 SHALL have port addr_bus  input  16  CPU address.
REQ-008 SHALL have port mem_data_out  input  8  CPU write data.
REQ-009 SHALL have port mem_data_in  output  8  read data returned to CPU, registered.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port rom_req  output  1  cartridge ROM read request.
REQ-013 SHALL have port rom_addr  output  15  ROM byte address, equal to addr_bus[14:0] of the accepted request.
REQ-014 SHALL have port rom_data  input  8  ROM read data, valid with rom_ack.
REQ-015 SHALL have port rom_ack  input  1  ROM data-valid strobe.
REQ-016 SHALL have port bus_err  output  1  one-cycle pulse on ROM timeout.

Function
REQ-017 SHALL register the previous memory_access sample (prev_acc) every cycle.
REQ-018 SHALL accept a request at an edge where state = IDLE, memory_access = 1 and prev_acc = 0 (edge A).
REQ-019 SHALL latch addr_bus, rw_n and mem_data_out at edge A and use only the latched copies afterwards.
REQ-020 SHALL ignore memory_access rising edges while busy; such requests are dropped, not queued.
REQ-021 SHALL decode the latched address as RAM for 0x0000-0x1FFF, indexed by addr[RAM_AW-1:0] so that the 2 KB array mirrors four times.
REQ-022 SHALL decode 0x8000-0xFFFF as ROM.
REQ-023 SHALL treat all other addresses as unmapped.
REQ-024 SHALL implement the states IDLE, RAM, ROM_WAIT and MISC.
REQ-025 SHALL transition IDLE->RAM at edge A for RAM hits, then RAM->IDLE at edge A+1.
REQ-026 SHALL, for a RAM read, load mem_data_in at edge A+1 and hold mem_ready high for the cycle after edge A+1.
REQ-027 SHALL, for a RAM write, write the array at edge A+1, leave mem_data_in unchanged and assert mem_ready for the cycle after edge A+1.
REQ-028 SHALL transition IDLE->ROM_WAIT at edge A for ROM reads, with rom_req high from the cycle after edge A until completion.
REQ-029 SHALL, at the first edge in ROM_WAIT where rom_ack = 1, load rom_data into mem_data_in, deassert rom_req, pulse mem_ready for one cycle and return to IDLE.
REQ-030 SHALL use a wait counter that starts at 0 at edge A and increments once per ROM_WAIT edge.
REQ-031 SHALL, when the wait counter reaches ROM_TIMEOUT without rom_ack, leave mem_data_in unchanged (open bus), pulse bus_err and mem_ready together for one cycle, drop rom_req and return to IDLE.
REQ-032 SHALL give rom_ack priority over timeout when both occur on the same edge.
REQ-033 SHALL ignore rom_ack while the state is not ROM_WAIT.
REQ-034 SHALL route ROM writes and unmapped reads or writes IDLE->MISC->IDLE: no RAM/ROM activity, mem_data_in unchanged, mem_ready for the cycle after edge A+1.
REQ-035 SHALL complete an accepted transaction even if memory_access falls before completion.
REQ-036 SHALL hold mem_data_in at its last loaded value between reads.
REQ-037 SHALL never assert mem_ready and busy together in the same cycle.

Reset
REQ-038 SHALL, when rst = 1 at an edge, set state to IDLE and clear mem_data_in, mem_ready, busy, rom_req, rom_addr, bus_err, prev_acc and the wait counter to 0.
REQ-039 SHALL, on reset during ROM_WAIT or RAM, abort the transaction with no mem_ready, no bus_err and no RAM write.
REQ-040 SHALL leave RAM contents unchanged by reset.
REQ-041 SHALL accept memory_access held at 1 across reset release as a new request at the first non-reset edge, since prev_acc = 0.

Verification
REQ-042 SHALL verify: write 0x5A to 0x0005, then read 0x1805 -> mem_ready one cycle after edge A+1, mem_data_in = 0x5A.
REQ-043 SHALL verify: read 0x8123 with rom_ack arriving 3 cycles later carrying 0xC3 -> rom_addr = 0x0123, mem_data_in = 0xC3, mem_ready pulses once, bus_err = 0.
REQ-044 SHALL verify: read 0xFFFC with no rom_ack -> bus_err and mem_ready pulse after 15 ROM_WAIT edges, mem_data_in retains the prior value.
REQ-045 SHALL verify: read 0x4016 (unmapped) after a RAM read of 0x77 -> mem_data_in stays 0x77, mem_ready pulses.
REQ-046 SHALL verify: a second memory_access rising edge during ROM_WAIT -> dropped, exactly one mem_ready.
REQ-047 SHALL verify: rst asserted mid-ROM_WAIT -> all outputs 0 next cycle, no mem_ready, and RAM data written earlier is still readable afterwards.
